operand_exec_unit: RTL and testbench

Execution stage of first_cpu, directly downstream of the two operand ROMs (`src1_memory` and `src2_memory`). On a start request, the block:
- drives the 2-bit read addresses to both ROMs,
- waits out their one-cycle registered read latency,
- captures the two 8-bit operands,
- performs the requested ALU operation.

Single-cycle operations finish three cycles after start. Multiply is an 8-cycle shift-add. The result, carry and zero flags are registered and held until the next operation completes.

---
 rtl/operand_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_operand_exec_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/operand_exec_unit.sv
// Execution stage of first_cpu: fetches two operands from the registered operand ROMs,
// runs a single-cycle ALU op or an 8-step shift-add multiply, and holds the registered result/flags.
module operand_exec_unit #(
   parameter int WIDTH     = 8,
   parameter int MUL_STEPS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [1:0]       src1_sel,
   input  logic [1:0]       src2_sel,
   output logic [1:0]       src1_addr,
   output logic [1:0]       src2_addr,
   input  logic [WIDTH-1:0] src1_value,
   input  logic [WIDTH-1:0] src2_value,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             busy,
   output logic             done
);

   localparam int STEP_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   localparam int ACC_W  = 2 * WIDTH;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LOAD,
      S_MUL,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_SHL  = 3'b101,
      OP_MUL  = 3'b110,
      OP_PASS = 3'b111
   } opcode_e;

   state_e             state_q,     state_d;
   opcode_e            opcode_q,    opcode_d;
   logic [1:0]         src1_addr_q, src1_addr_d;
   logic [1:0]         src2_addr_q, src2_addr_d;
   logic [WIDTH-1:0]   op_a_q,      op_a_d;
   logic [WIDTH-1:0]   op_b_q,      op_b_d;
   logic [ACC_W-1:0]   acc_q,       acc_d;
   logic [STEP_W-1:0]  step_q,      step_d;
   logic [WIDTH-1:0]   result_q,    result_d;
   logic               carry_q,     carry_d;
   logic               zero_q,      zero_d;

   logic [WIDTH:0]     alu_wide;
   logic [ACC_W-1:0]   partial;
   logic [ACC_W-1:0]   acc_sum;

   // Single-cycle ALU works straight off the ROM data in LOAD; the top bit is the carry/borrow flag.
   always_comb begin
      alu_wide = '0;
      case (opcode_q)
         OP_ADD:  alu_wide = {1'b0, src1_value} + {1'b0, src2_value};
         OP_SUB:  alu_wide = {(src1_value < src2_value), src1_value - src2_value};
         OP_AND:  alu_wide = {1'b0, src1_value & src2_value};
         OP_OR:   alu_wide = {1'b0, src1_value | src2_value};
         OP_XOR:  alu_wide = {1'b0, src1_value ^ src2_value};
         OP_SHL:  alu_wide = {1'b0, src1_value} << src2_value[2:0];
         OP_PASS: alu_wide = {1'b0, src1_value};
         default: alu_wide = '0;
      endcase
   end

   // Shift-add multiply: one partial product per step, selected by the current multiplier bit.
   always_comb begin
      partial = '0;
      if (op_b_q[step_q]) begin
         partial = {{WIDTH{1'b0}}, op_a_q} << step_q;
      end
      acc_sum = acc_q + partial;
   end

   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      src1_addr_d = src1_addr_q;
      src2_addr_d = src2_addr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      acc_d       = acc_q;
      step_d      = step_q;
      result_d    = result_q;
      carry_d     = carry_q;
      zero_d      = zero_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               opcode_d    = opcode_e'(opcode);
               src1_addr_d = src1_sel;
               src2_addr_d = src2_sel;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            op_a_d = src1_value;
            op_b_d = src2_value;
            if (opcode_q == OP_MUL) begin
               acc_d   = '0;
               step_d  = '0;
               state_d = S_MUL;
            end else begin
               result_d = alu_wide[WIDTH-1:0];
               carry_d  = alu_wide[WIDTH];
               zero_d   = (alu_wide[WIDTH-1:0] == '0);
               state_d  = S_DONE;
            end
         end
         S_MUL: begin
            acc_d  = acc_sum;
            step_d = step_q + 1'b1;
            // The last step's partial product must already be in the written result.
            if (step_q == LAST_STEP) begin
               result_d = acc_sum[WIDTH-1:0];
               carry_d  = |acc_sum[ACC_W-1:WIDTH];
               zero_d   = (acc_sum[WIDTH-1:0] == '0);
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         opcode_q    <= OP_ADD;
         src1_addr_q <= '0;
         src2_addr_q <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         acc_q       <= '0;
         step_q      <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         src1_addr_q <= src1_addr_d;
         src2_addr_q <= src2_addr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         acc_q       <= acc_d;
         step_q      <= step_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
      end
   end

   assign src1_addr = src1_addr_q;
   assign src2_addr = src2_addr_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign busy      = (state_q == S_ISSUE) || (state_q == S_LOAD) || (state_q == S_MUL);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_operand_exec_unit.sv
// Directed bench for operand_exec_unit with behavioural models of the two registered operand ROMs.
module tb_operand_exec_unit;

   logic       clk;
   logic       reset;
   logic       start;
   logic [2:0] opcode;
   logic [1:0] src1Sel;
   logic [1:0] src2Sel;
   logic [1:0] src1Addr;
   logic [1:0] src2Addr;
   logic [7:0] src1Value;
   logic [7:0] src2Value;
   logic [7:0] result;
   logic       carry;
   logic       zero;
   logic       busy;
   logic       done;

   int passCount  = 0;
   int totalCount = 0;

   logic [7:0] rom1 [4];
   logic [7:0] rom2 [4];

   int lat;
   int busyCycles;
   int doneCount;
   logic [1:0] firstAddr1;
   logic [1:0] firstAddr2;

   localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                          OP_SHL = 3'b101, OP_MUL = 3'b110;

   operand_exec_unit #(.WIDTH(8), .MUL_STEPS(8)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .opcode(opcode),
      .src1_sel(src1Sel),
      .src2_sel(src2Sel),
      .src1_addr(src1Addr),
      .src2_addr(src2Addr),
      .src1_value(src1Value),
      .src2_value(src2Value),
      .result(result),
      .carry(carry),
      .zero(zero),
      .busy(busy),
      .done(done)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Operand ROMs with a one-cycle registered read.
   always @(posedge clk) begin
      src1Value <= rom1[src1Addr];
      src2Value <= rom2[src2Addr];
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   // Issues one start pulse and follows the op until done (bounded), measuring latency and busy time.
   task automatic applyStimulus(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2);
      bit seenDone;
      @(negedge clk);
      start = 1'b1; opcode = op; src1Sel = s1; src2Sel = s2;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; busyCycles = 0; doneCount = 0; seenDone = 0;
      for (int c = 0; c < 30 && !seenDone; c++) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            firstAddr1 = src1Addr;
            firstAddr2 = src2Addr;
         end
         if (busy) busyCycles++;
         if (done) begin
            seenDone = 1;
            doneCount++;
         end
      end
   endtask

   initial begin
      rom1[0] = 8'h03; rom1[1] = 8'h80; rom1[2] = 8'hFF; rom1[3] = 8'h00;
      rom2[0] = 8'hF0; rom2[1] = 8'h4E; rom2[2] = 8'h99; rom2[3] = 8'h25;

      // Reset held two cycles with start asserted.
      reset = 1'b1; start = 1'b1; opcode = OP_ADD; src1Sel = 2'd1; src2Sel = 2'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_result", {8'h0, result}, 16'h0000);
      checkOutput("reset_carry", {15'h0, carry}, 16'h0000);
      checkOutput("reset_zero", {15'h0, zero}, 16'h0000);
      checkOutput("reset_busy", {15'h0, busy}, 16'h0000);
      checkOutput("reset_done", {15'h0, done}, 16'h0000);
      checkOutput("reset_addr1", {14'h0, src1Addr}, 16'h0000);
      checkOutput("reset_addr2", {14'h0, src2Addr}, 16'h0000);
      start = 1'b0;
      reset = 1'b0;

      // ADD 80+F0 = 170.
      applyStimulus(OP_ADD, 2'd1, 2'd0);
      checkOutput("add_latency", 16'(lat), 16'd3);
      checkOutput("add_addr1", {14'h0, firstAddr1}, 16'd1);
      checkOutput("add_addr2", {14'h0, firstAddr2}, 16'd0);
      checkOutput("add_result", {8'h0, result}, 16'h0070);
      checkOutput("add_carry", {15'h0, carry}, 16'd1);
      checkOutput("add_zero", {15'h0, zero}, 16'd0);
      checkOutput("add_busy_cycles", 16'(busyCycles), 16'd2);

      // SUB 00-25 borrows.
      applyStimulus(OP_SUB, 2'd3, 2'd3);
      checkOutput("sub_result", {8'h0, result}, 16'h00DB);
      checkOutput("sub_carry", {15'h0, carry}, 16'd1);
      checkOutput("sub_zero", {15'h0, zero}, 16'd0);

      // AND 00&99 = 0.
      applyStimulus(OP_AND, 2'd3, 2'd2);
      checkOutput("and_result", {8'h0, result}, 16'h0000);
      checkOutput("and_carry", {15'h0, carry}, 16'd0);
      checkOutput("and_zero", {15'h0, zero}, 16'd1);

      // SHL 03<<5 and 80<<1.
      applyStimulus(OP_SHL, 2'd0, 2'd3);
      checkOutput("shl5_result", {8'h0, result}, 16'h0060);
      checkOutput("shl5_carry", {15'h0, carry}, 16'd0);
      checkOutput("shl5_zero", {15'h0, zero}, 16'd0);
      applyStimulus(OP_SHL, 2'd1, 2'd2);
      checkOutput("shl1_result", {8'h0, result}, 16'h0000);
      checkOutput("shl1_carry", {15'h0, carry}, 16'd1);
      checkOutput("shl1_zero", {15'h0, zero}, 16'd1);

      // MUL 03*4E = 00EA.
      applyStimulus(OP_MUL, 2'd0, 2'd1);
      checkOutput("mul_latency", 16'(lat), 16'd11);
      checkOutput("mul_busy_cycles", 16'(busyCycles), 16'd10);
      checkOutput("mul_result", {8'h0, result}, 16'h00EA);
      checkOutput("mul_carry", {15'h0, carry}, 16'd0);
      checkOutput("mul_zero", {15'h0, zero}, 16'd0);

      // MUL FF*25 = 24DB.
      applyStimulus(OP_MUL, 2'd2, 2'd3);
      checkOutput("mul2_latency", 16'(lat), 16'd11);
      checkOutput("mul2_result", {8'h0, result}, 16'h00DB);
      checkOutput("mul2_carry", {15'h0, carry}, 16'd1);

      // Result holds in idle.
      repeat (4) @(negedge clk);
      checkOutput("hold_result", {8'h0, result}, 16'h00DB);
      checkOutput("hold_done", {15'h0, done}, 16'd0);

      // Start pulses while busy and in DONE must be ignored.
      @(negedge clk);
      start = 1'b1; opcode = OP_MUL; src1Sel = 2'd0; src2Sel = 2'd1;
      @(posedge clk);
      #1 opcode = OP_ADD; src1Sel = 2'd2; src2Sel = 2'd2;
      doneCount = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (done) doneCount++;
         if (doneCount > 0 && !done) start = 1'b0;
         if (c == 2) checkOutput("busy_result_held", {8'h0, result}, 16'h00DB);
      end
      start = 1'b0;
      checkOutput("ignore_done_count", 16'(doneCount), 16'd1);
      checkOutput("ignore_result", {8'h0, result}, 16'h00EA);
      checkOutput("ignore_carry", {15'h0, carry}, 16'd0);
      checkOutput("ignore_busy", {15'h0, busy}, 16'd0);

      // Reset during MUL step 4 aborts with no done pulse.
      @(negedge clk);
      start = 1'b1; opcode = OP_MUL; src1Sel = 2'd2; src2Sel = 2'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort_result", {8'h0, result}, 16'h0000);
      checkOutput("abort_carry", {15'h0, carry}, 16'd0);
      checkOutput("abort_busy", {15'h0, busy}, 16'd0);
      checkOutput("abort_addr1", {14'h0, src1Addr}, 16'd0);
      doneCount = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("abort_no_done", 16'(doneCount), 16'd0);

      applyStimulus(OP_ADD, 2'd1, 2'd0);
      checkOutput("post_abort_latency", 16'(lat), 16'd3);
      checkOutput("post_abort_result", {8'h0, result}, 16'h0070);
      checkOutput("post_abort_carry", {15'h0, carry}, 16'd1);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
